// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-entry skid buffer and redirect/flush.
// Optional HLT detection and HALT state are enabled by defining FETCH_HALT_DETECT_EN.
module fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [5:0]        id_opcode,
  output logic [ADDR_W-1:0] id_pc4,
  output logic              halted,
  output logic [31:0]       fetch_count
);

`ifdef FETCH_HALT_DETECT_EN
  localparam logic [5:0] HLT_OPCODE = 6'b111111;
  typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;
`else
  typedef enum logic [1:0] {FETCH, HOLD} state_t;
`endif

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic [31:0]         skid_instr_reg, skid_instr_next;
  logic [ADDR_W-1:0]   skid_pc4_reg, skid_pc4_next;
  logic                id_valid_reg, id_valid_next;
  logic [31:0]         id_instr_reg, id_instr_next;
  logic [ADDR_W-1:0]   id_pc4_reg, id_pc4_next;
  logic [31:0]         fetch_count_reg, fetch_count_next;

  logic                load_id;
  logic [31:0]         load_instr;
  logic [ADDR_W-1:0]   load_pc4;
  logic [ADDR_W-1:0]   pc_plus4;
  logic [ADDR_W-1:0]   redirect_target;

  assign pc_plus4        = pc_reg + ADDR_W'(4);
  assign redirect_target = redirect_pc & ~(ADDR_W'(3));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= FETCH;
      pc_reg          <= RESET_PC;
      skid_instr_reg  <= '0;
      skid_pc4_reg    <= '0;
      id_valid_reg    <= 1'b0;
      id_instr_reg    <= '0;
      id_pc4_reg      <= '0;
      fetch_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      skid_instr_reg  <= skid_instr_next;
      skid_pc4_reg    <= skid_pc4_next;
      id_valid_reg    <= id_valid_next;
      id_instr_reg    <= id_instr_next;
      id_pc4_reg      <= id_pc4_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    skid_instr_next  = skid_instr_reg;
    skid_pc4_next    = skid_pc4_reg;
    id_valid_next    = id_valid_reg;
    id_instr_next    = id_instr_reg;
    id_pc4_next      = id_pc4_reg;
    fetch_count_next = fetch_count_reg;
    load_id          = 1'b0;
    load_instr       = '0;
    load_pc4         = '0;

    case (state_reg)
      FETCH: begin
        // A redirect drops any response arriving in the same cycle.
        if (redirect_valid) begin
          pc_next       = redirect_target;
          id_valid_next = 1'b0;
        end else if (imem_ready) begin
          pc_next = pc_plus4;
          if (stall) begin
            skid_instr_next = imem_rdata;
            skid_pc4_next   = pc_plus4;
            state_next      = HOLD;
          end else begin
            load_id    = 1'b1;
            load_instr = imem_rdata;
            load_pc4   = pc_plus4;
          end
        end else if (!stall) begin
          id_valid_next = 1'b0;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_next       = redirect_target;
          id_valid_next = 1'b0;
          state_next    = FETCH;
        end else if (!stall) begin
          load_id    = 1'b1;
          load_instr = skid_instr_reg;
          load_pc4   = skid_pc4_reg;
          state_next = FETCH;
        end
      end
`ifdef FETCH_HALT_DETECT_EN
      HALT: begin
        // Decode consumes the HLT on its first unstalled cycle.
        if (!stall) begin
          id_valid_next = 1'b0;
        end
      end
`endif
      default: state_next = FETCH;
    endcase

    if (load_id) begin
      id_instr_next    = load_instr;
      id_pc4_next      = load_pc4;
      id_valid_next    = 1'b1;
      fetch_count_next = fetch_count_reg + 32'd1;
`ifdef FETCH_HALT_DETECT_EN
      if (load_instr[31:26] == HLT_OPCODE) begin
        state_next = HALT;
      end
`endif
    end
  end

  assign imem_req    = (state_reg == FETCH) && !rst;
  assign imem_addr   = pc_reg;
  assign id_valid    = id_valid_reg;
  assign id_instr    = id_instr_reg;
  assign id_opcode   = id_instr_reg[31:26];
  assign id_pc4      = id_pc4_reg;
  assign fetch_count = fetch_count_reg;

`ifdef FETCH_HALT_DETECT_EN
  assign halted = (state_reg == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: zero-wait fetch, stall/skid, redirect,
// PC wrap, HLT handling (either build) and reset while holding a skid entry.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [31:0] id_pc4;
  logic        halted;
  logic [31:0] fetch_count;

  int tests  = 0;
  int failed = 0;
  logic hlt_at_8 = 1'b0;

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_opcode     (id_opcode),
    .id_pc4        (id_pc4),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  // Memory word at address a: opcode 1 with the low 26 address bits; optional HLT at 0x8.
  assign imem_rdata = (hlt_at_8 && imem_addr == 32'h8) ? 32'hFC00_0000
                                                       : {6'h01, imem_addr[25:0]};

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        idv;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then settle 1ns past it for sampling.
  task automatic step(input logic s, input logic rv, input logic [31:0] rpc, input logic rdy);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ready     = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            stall rv rpc           rdy  req addr          idv instr         pc4           cnt
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b1, 32'h0400_0000, 32'h4,  32'd1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        1'b1, 32'h0400_0004, 32'h8,  32'd2};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        1'b1, 32'h0400_0008, 32'hC,  32'd3};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hC,        1'b0, 32'h0400_0008, 32'hC,  32'd3};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       1'b1, 32'h0400_000C, 32'h10, 32'd4};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h14,       1'b1, 32'h0400_000C, 32'h10, 32'd4};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h14,       1'b1, 32'h0400_000C, 32'h10, 32'd4};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h14,       1'b1, 32'h0400_000C, 32'h10, 32'd4};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h14,       1'b1, 32'h0400_0010, 32'h14, 32'd5};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h18,       1'b1, 32'h0400_0014, 32'h18, 32'd6};
    vecs[10] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1C,       1'b1, 32'h0400_0014, 32'h18, 32'd6};
    vecs[11] = '{1'b1, 1'b1, 32'h43,       1'b0, 1'b1, 32'h40,       1'b0, 32'h0400_0014, 32'h18, 32'd6};
    vecs[12] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h40,       1'b0, 32'h0400_0014, 32'h18, 32'd6};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h44,       1'b1, 32'h0400_0040, 32'h44, 32'd7};
    vecs[14] = '{1'b0, 1'b1, 32'h100,      1'b1, 1'b1, 32'h100,      1'b0, 32'h0400_0040, 32'h44, 32'd7};
    vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      1'b1, 32'h0400_0100, 32'h104, 32'd8};
    vecs[16] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0400_0100, 32'h104, 32'd8};
    vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b1, 32'h07FF_FFFC, 32'h0,  32'd9};
    vecs[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b1, 32'h0400_0000, 32'h4,  32'd10};

    // Reset state, sampled while rst is still high.
    rst = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_idv", {31'b0, id_valid}, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc4", id_pc4, 32'h0);
    chk("rst_cnt", fetch_count, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    rst = 1'b0;
    #1;
    chk("first_req", {31'b0, imem_req}, 32'h1);

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("v%0d_idv", i), {31'b0, id_valid}, {31'b0, vecs[i].idv});
      chk($sformatf("v%0d_instr", i), id_instr, vecs[i].instr);
      chk($sformatf("v%0d_pc4", i), id_pc4, vecs[i].pc4);
      chk($sformatf("v%0d_cnt", i), fetch_count, vecs[i].cnt);
      chk($sformatf("v%0d_halted", i), {31'b0, halted}, 32'h0);
      $display("[TB] vec %0d addr=%h id_valid=%0b id_instr=%h id_pc4=%h count=%0d",
               i, imem_addr, id_valid, id_instr, id_pc4, fetch_count);
    end

    // HLT word fetched at 0x8.
    hlt_at_8 = 1'b1;
    step(1'b0, 1'b1, 32'h8, 1'b0);
    chk("hlt_redir_addr", imem_addr, 32'h8);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("hlt_opcode", {26'b0, id_opcode}, 32'h3F);
    chk("hlt_instr", id_instr, 32'hFC00_0000);
    chk("hlt_cnt", fetch_count, 32'd11);
    chk("hlt_idv", {31'b0, id_valid}, 32'h1);
    $display("[TB] hlt capture halted=%0b imem_req=%0b addr=%h", halted, imem_req, imem_addr);
`ifdef FETCH_HALT_DETECT_EN
    chk("hlt_halted", {31'b0, halted}, 32'h1);
    chk("hlt_req", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      step((i == 0), 1'b1, 32'h200, 1'b1);
      chk($sformatf("halt%0d_req", i), {31'b0, imem_req}, 32'h0);
      chk($sformatf("halt%0d_halted", i), {31'b0, halted}, 32'h1);
      chk($sformatf("halt%0d_addr", i), imem_addr, 32'hC);
      chk($sformatf("halt%0d_idv", i), {31'b0, id_valid}, (i == 0) ? 32'h1 : 32'h0);
      chk($sformatf("halt%0d_cnt", i), fetch_count, 32'd11);
    end
    $display("[TB] halt hold done id_valid=%0b count=%0d", id_valid, fetch_count);
`else
    chk("nohlt_halted", {31'b0, halted}, 32'h0);
    chk("nohlt_req", {31'b0, imem_req}, 32'h1);
    chk("nohlt_addr", imem_addr, 32'hC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("nohlt_next_instr", id_instr, 32'h0400_000C);
    chk("nohlt_next_pc4", id_pc4, 32'h10);
    chk("nohlt_next_cnt", fetch_count, 32'd12);
    $display("[TB] no-halt continue id_instr=%h count=%0d", id_instr, fetch_count);
`endif
    hlt_at_8 = 1'b0;

    // Reset while in HOLD with a pending skid entry.
    rst = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rh_cap_cnt", fetch_count, 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rh_hold_req", {31'b0, imem_req}, 32'h0);
    chk("rh_hold_addr", imem_addr, 32'h8);
    rst = 1'b1;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rh_addr", imem_addr, 32'h0);
    chk("rh_idv", {31'b0, id_valid}, 32'h0);
    chk("rh_cnt", fetch_count, 32'h0);
    chk("rh_halted", {31'b0, halted}, 32'h0);
    chk("rh_instr", id_instr, 32'h0);
    chk("rh_pc4", id_pc4, 32'h0);
    rst = 1'b0;
    #1;
    chk("rh_req_after", {31'b0, imem_req}, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rh_no_skid_idv", {31'b0, id_valid}, 32'h0);
    chk("rh_no_skid_cnt", fetch_count, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rh_refetch_instr", id_instr, 32'h0400_0000);
    chk("rh_refetch_pc4", id_pc4, 32'h4);
    chk("rh_refetch_cnt", fetch_count, 32'd1);
    $display("[TB] reset-in-hold done id_instr=%h count=%0d", id_instr, fetch_count);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register: owns the PC, issues word fetches to instruction memory through a req/ready handshake, and presents the fetched instruction and its opcode to the control unit and decode logic. It handles pipeline stalls via a one-entry skid buffer, branch/jump redirects with flush, and detection of the HLT opcode (6'b111111), which freezes fetch.

## Interface
- ADDR_W, 32, PC / memory address width
- RESET_PC, 0, PC value loaded on reset (low 2 bits must be 0)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  fetch request, valid this cycle
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_ready  in  1  memory returns imem_rdata this cycle (may be same cycle as req)
- imem_rdata  in  32  fetched instruction word
- stall  in  1  decode cannot accept; IF/ID must hold
- redirect_valid  in  1  branch taken / jump; load redirect_pc, flush
- redirect_pc  in  ADDR_W  target PC; bits [1:0] ignored (forced 0)
- id_valid  out  1  IF/ID holds a live instruction
- id_instr  out  32  IF/ID instruction
- id_opcode  out  6  id_instr[31:26], to control unit opCode
- id_pc4  out  ADDR_W  PC of id_instr + 4
- halted  out  1  HLT captured, fetch frozen
- fetch_count  out  32  instructions delivered into IF/ID since reset

## Operation
- States: FETCH, HOLD, HALT. Reset -> FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ready:
  - stall=0: IF/ID <= {imem_rdata, pc+4}, id_valid<=1, pc<=pc+4, fetch_count++; stay FETCH.
  - stall=1: skid <= {imem_rdata, pc+4}, pc<=pc+4; -> HOLD. IF/ID unchanged.
  - No imem_ready: stay; if stall=0 id_valid<=0 (bubble).
- HOLD: imem_req=0. When stall=0: IF/ID <= skid, id_valid<=1, fetch_count++; -> FETCH.
- HALT entry: when a word with opcode 6'b111111 is written into IF/ID, next state HALT (it still appears in IF/ID, counted). HLT in skid takes effect when moved to IF/ID.
- HALT: imem_req=0, halted=1, IF/ID held (id_valid stays as last written while stall=1; cleared to 0 on first stall=0 cycle after HLT consumed). Exit only by rst.
- Redirect (redirect_valid=1, not in HALT): pc<=redirect_pc & ~3; id_valid<=0; skid discarded; -> FETCH; no fetch_count increment; any imem_ready response that cycle is dropped. Priority over stall, capture and HALT entry. Ignored in HALT.
- Arithmetic: pc+4 modulo 2^ADDR_W (0xFFFFFFFC wraps to 0). fetch_count wraps at 2^32.

## Timing
- Reset values: pc=RESET_PC, id_valid=0, id_instr=0, id_pc4=0, halted=0, fetch_count=0, imem_req=0 during rst cycle, state FETCH, skid empty.
- First imem_req the cycle after rst deasserts.
- Zero-wait memory: one instruction per cycle; id_instr valid the cycle after imem_ready.
- Redirect: imem_addr=target the cycle after redirect_valid; first target instruction in IF/ID ≥2 cycles after redirect.
- HOLD -> IF/ID transfer: 1 cycle after stall falls; next fetch the following cycle.
- rst mid-operation (any state, pending skid, pending response) returns to reset values next edge; simultaneous rst wins over everything.
- Simultaneous redirect and stall: redirect wins; IF/ID flushed despite stall.

## Configuration
- FETCH_HALT_DETECT_EN: defined -> HLT detection and HALT state as above. Undefined -> opcode 6'b111111 treated as an ordinary instruction, HALT state absent, halted tied 0.

## Test plan
- Reset, zero-wait memory with imem_rdata=0x00000000 at 0,4,8 -> imem_addr 0,4,8 on consecutive cycles; id_pc4 4,8,12; fetch_count 3 after 3 captures.
- stall=1 for 3 cycles during response at pc=0x10 -> IF/ID held, HOLD, imem_req=0; stall drop -> id_instr=word@0x10 next cycle, next imem_addr=0x14.
- redirect_valid with redirect_pc=0x43 while stall=1 and skid full -> id_valid=0 next cycle, imem_addr=0x40, skid word never delivered, fetch_count unchanged.
- Fetch 0xFC000000 at 0x8 (macro on) -> id_opcode=6'b111111, halted=1 next cycle, imem_req stays 0 for 20 cycles, redirect ignored; macro off -> fetch continues at 0xC.
- pc=0xFFFFFFFC with ready -> next imem_addr=0x00000000, id_pc4=0.
- rst asserted in HOLD with pending skid -> next cycle pc=RESET_PC, id_valid=0, fetch_count=0, halted=0.
